// File: rtl/cu_noc_pkg.sv
// cu_noc_pkg: shared widths and the agent state encoding for the CU NoC
// command agent and its config register file.
package cu_noc_pkg;

    localparam int unsigned NOC_CMD_W       = 3;
    localparam int unsigned NOC_CFG_AW      = 7;
    localparam int unsigned NOC_CFG_DW      = 13;
    localparam int unsigned NOC_DESC_W      = 52;
    localparam int unsigned NOC_SLOT_STRIDE = 16;
    localparam int unsigned NOC_DESC_WORDS  = 4;

    typedef enum logic [2:0] {
        NOC_ST_IDLE  = 3'd0,
        NOC_ST_GNT   = 3'd1,
        NOC_ST_ISSUE = 3'd2,
        NOC_ST_WAIT  = 3'd3,
        NOC_ST_OK    = 3'd4
    } noc_agent_st_e;

    // First register of descriptor slot d (slots are NOC_SLOT_STRIDE apart).
    function automatic logic [NOC_CFG_AW-1:0] noc_slot_base(input logic [NOC_CMD_W-1:0] d);
        return NOC_CFG_AW'(d) << $clog2(NOC_SLOT_STRIDE);
    endfunction

endpackage

// File: rtl/cu_noc_cfg_rf.sv
// cu_noc_cfg_rf: config register file, one write port and one registered
// four-word read port aligned to a descriptor slot.
//   clk, rst      : clock, synchronous active-high reset (clears all words)
//   wr_en_i/...   : write strobe, address, data (never blocked)
//   rd_en_i       : capture the slot's four words into rd_data_o
//   rd_slot_i     : descriptor slot index d (base address 16*d)
//   rd_data_o     : {rf[base+3], rf[base+2], rf[base+1], rf[base]}, held until next rd_en_i
module cu_noc_cfg_rf
    import cu_noc_pkg::*;
#(
    parameter int unsigned AW = NOC_CFG_AW,
    parameter int unsigned DW = NOC_CFG_DW
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en_i,
    input  logic [AW-1:0]                      wr_addr_i,
    input  logic [DW-1:0]                      wr_data_i,
    input  logic                               rd_en_i,
    input  logic [NOC_CMD_W-1:0]               rd_slot_i,
    output logic [NOC_DESC_WORDS*DW-1:0]       rd_data_o
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned SHIFT = $clog2(NOC_SLOT_STRIDE);

    logic [DW-1:0]                   mem_q [DEPTH];
    logic [NOC_DESC_WORDS*DW-1:0]    rd_data_d, rd_data_q;
    logic [AW-1:0]                   rd_base;

    assign rd_base = AW'(rd_slot_i) << SHIFT;

    // Storage array; a write lands at the same edge a read captures, so the
    // capture sees the pre-write value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Slot read: gather four consecutive words, lowest address in the LSBs.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            for (int k = 0; k < NOC_DESC_WORDS; k++) begin
                rd_data_d[k*DW +: DW] = mem_q[rd_base + AW'(k)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cu_noc_cmd_agent.sv
// cu_noc_cmd_agent: accepts core commands over req/gnt, issues a config
// descriptor snapshot to the NoC DMA engine, returns ok on completion and
// wakes the core if it slept while the command was outstanding.
//   clk, rst                 : clock, synchronous active-high reset
//   cmd_req_i/cmd_addr_i     : command request and slot index; cmd_gnt_o one-cycle grant
//   cmd_ok_o                 : one-cycle completion pulse
//   cfg_vld_i/addr/data      : config register writes
//   core_sleep_en_i          : core entering sleep; core_wakeup_irq_o wake pulse
//   desc_vld_o/desc_rdy_i    : descriptor handshake; desc_cmd_o/desc_data_o payload
//   dma_done_i               : DMA completion pulse
//   err_o                    : sticky timeout flag
module cu_noc_cmd_agent
    import cu_noc_pkg::*;
#(
    parameter int unsigned CFG_AW  = NOC_CFG_AW,
    parameter int unsigned CFG_DW  = NOC_CFG_DW,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_req_i,
    input  logic [NOC_CMD_W-1:0]   cmd_addr_i,
    output logic                   cmd_gnt_o,
    output logic                   cmd_ok_o,
    input  logic                   cfg_vld_i,
    input  logic [CFG_AW-1:0]      cfg_addr_i,
    input  logic [CFG_DW-1:0]      cfg_data_i,
    input  logic                   core_sleep_en_i,
    output logic                   core_wakeup_irq_o,
    output logic                   desc_vld_o,
    input  logic                   desc_rdy_i,
    output logic [NOC_CMD_W-1:0]   desc_cmd_o,
    output logic [4*CFG_DW-1:0]    desc_data_o,
    input  logic                   dma_done_i,
    output logic                   err_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ST_IDLE  = 3'(NOC_ST_IDLE);
    localparam logic [2:0] ST_GNT   = 3'(NOC_ST_GNT);
    localparam logic [2:0] ST_ISSUE = 3'(NOC_ST_ISSUE);
    localparam logic [2:0] ST_WAIT  = 3'(NOC_ST_WAIT);
    localparam logic [2:0] ST_OK    = 3'(NOC_ST_OK);

    logic [2:0]            state_d, state_q;
    logic [NOC_CMD_W-1:0]  slot_d, slot_q;
    logic [NOC_CMD_W-1:0]  desc_cmd_d, desc_cmd_q;
    logic [CNT_W-1:0]      cnt_d, cnt_q;
    logic                  gnt_d, gnt_q;
    logic                  ok_d, ok_q;
    logic                  vld_d, vld_q;
    logic                  err_d, err_q;
    logic                  sleep_d, sleep_q;
    logic                  snap_c;

    cu_noc_cfg_rf #(
        .AW (CFG_AW),
        .DW (CFG_DW)
    ) u_cfg_rf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (cfg_vld_i),
        .wr_addr_i (cfg_addr_i),
        .wr_data_i (cfg_data_i),
        .rd_en_i   (snap_c),
        .rd_slot_i (slot_q),
        .rd_data_o (desc_data_o)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        desc_cmd_d = desc_cmd_q;
        cnt_d      = cnt_q;
        gnt_d      = 1'b0;
        ok_d       = 1'b0;
        vld_d      = vld_q;
        err_d      = err_q;
        sleep_d    = sleep_q;
        snap_c     = 1'b0;

        // Only remember sleep while a command is outstanding.
        if (core_sleep_en_i &&
            (state_q == ST_GNT || state_q == ST_ISSUE || state_q == ST_WAIT)) begin
            sleep_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_req_i) begin
                    slot_d  = cmd_addr_i;
                    gnt_d   = 1'b1;
                    state_d = ST_GNT;
                end
            end
            ST_GNT: begin
                snap_c     = 1'b1;
                desc_cmd_d = slot_q;
                vld_d      = 1'b1;
                state_d    = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (desc_rdy_i) begin
                    vld_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Completion takes priority over a coincident timeout.
                if (dma_done_i) begin
                    ok_d    = 1'b1;
                    state_d = ST_OK;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    ok_d    = 1'b1;
                    state_d = ST_OK;
                end
            end
            ST_OK: begin
                sleep_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            slot_q     <= '0;
            desc_cmd_q <= '0;
            cnt_q      <= '0;
            gnt_q      <= 1'b0;
            ok_q       <= 1'b0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
            sleep_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            desc_cmd_q <= desc_cmd_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            ok_q       <= ok_d;
            vld_q      <= vld_d;
            err_q      <= err_d;
            sleep_q    <= sleep_d;
        end
    end

    assign cmd_gnt_o  = gnt_q;
    assign cmd_ok_o   = ok_q;
    assign desc_vld_o = vld_q;
    assign desc_cmd_o = desc_cmd_q;
    assign err_o      = err_q;

    // Wake-up rides the ok pulse; a sleep request arriving in the OK cycle itself also counts.
    assign core_wakeup_irq_o = ok_q & (sleep_q | core_sleep_en_i);

endmodule

// File: tb/tb_cu_noc_cmd_agent.sv
// Directed self-checking bench for cu_noc_cmd_agent.
module tb_cu_noc_cmd_agent;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_req_i;
    logic [2:0]  cmd_addr_i;
    logic        cmd_gnt_o;
    logic        cmd_ok_o;
    logic        cfg_vld_i;
    logic [6:0]  cfg_addr_i;
    logic [12:0] cfg_data_i;
    logic        core_sleep_en_i;
    logic        core_wakeup_irq_o;
    logic        desc_vld_o;
    logic        desc_rdy_i;
    logic [2:0]  desc_cmd_o;
    logic [51:0] desc_data_o;
    logic        dma_done_i;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    cu_noc_cmd_agent #(
        .CFG_AW  (7),
        .CFG_DW  (13),
        .TIMEOUT (1024)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_req_i         (cmd_req_i),
        .cmd_addr_i        (cmd_addr_i),
        .cmd_gnt_o         (cmd_gnt_o),
        .cmd_ok_o          (cmd_ok_o),
        .cfg_vld_i         (cfg_vld_i),
        .cfg_addr_i        (cfg_addr_i),
        .cfg_data_i        (cfg_data_i),
        .core_sleep_en_i   (core_sleep_en_i),
        .core_wakeup_irq_o (core_wakeup_irq_o),
        .desc_vld_o        (desc_vld_o),
        .desc_rdy_i        (desc_rdy_i),
        .desc_cmd_o        (desc_cmd_o),
        .desc_data_o       (desc_data_o),
        .dma_done_i        (dma_done_i),
        .err_o             (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_wr(input logic [6:0] a, input logic [12:0] d);
        cfg_vld_i  = 1'b1;
        cfg_addr_i = a;
        cfg_data_i = d;
        tick();
        cfg_vld_i  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},  64'(cmd_gnt_o), 64'd0);
        chk({tag, "_ok"},   64'(cmd_ok_o), 64'd0);
        chk({tag, "_irq"},  64'(core_wakeup_irq_o), 64'd0);
        chk({tag, "_vld"},  64'(desc_vld_o), 64'd0);
        chk({tag, "_cmd"},  64'(desc_cmd_o), 64'd0);
        chk({tag, "_data"}, 64'(desc_data_o), 64'd0);
        chk({tag, "_err"},  64'(err_o), 64'd0);
    endtask

    logic [51:0] exp_desc;
    logic [51:0] held;
    int          n;
    int          ok_cnt;

    initial begin
        rst = 1'b1; cmd_req_i = 1'b0; cmd_addr_i = '0; cfg_vld_i = 1'b0;
        cfg_addr_i = '0; cfg_data_i = '0; core_sleep_en_i = 1'b0;
        desc_rdy_i = 1'b0; dma_done_i = 1'b0;
        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Config then command d=2, minimum latency path.
        cfg_wr(7'd32, 13'h001);
        cfg_wr(7'd33, 13'h002);
        cfg_wr(7'd34, 13'h003);
        cfg_wr(7'd35, 13'h004);
        exp_desc = {13'h004, 13'h003, 13'h002, 13'h001};
        cmd_req_i = 1'b1; cmd_addr_i = 3'd2; desc_rdy_i = 1'b1;
        tick();                                      // t+1
        chk("c1_gnt", 64'(cmd_gnt_o), 64'd1);
        chk("c1_vld_in_gnt", 64'(desc_vld_o), 64'd0);
        cmd_req_i = 1'b0;
        tick();                                      // t+2
        chk("c1_gnt_drop", 64'(cmd_gnt_o), 64'd0);
        chk("c1_vld", 64'(desc_vld_o), 64'd1);
        chk("c1_data", 64'(desc_data_o), 64'(exp_desc));
        chk("c1_cmd", 64'(desc_cmd_o), 64'd2);
        tick();                                      // t+3, WAIT
        chk("c1_vld_drop", 64'(desc_vld_o), 64'd0);
        chk("c1_ok_early", 64'(cmd_ok_o), 64'd0);
        dma_done_i = 1'b1;
        tick();                                      // t+4, OK
        dma_done_i = 1'b0;
        chk("c1_ok", 64'(cmd_ok_o), 64'd1);
        chk("c1_irq", 64'(core_wakeup_irq_o), 64'd0);
        chk("c1_err", 64'(err_o), 64'd0);
        tick();
        chk("c1_ok_drop", 64'(cmd_ok_o), 64'd0);

        // Backpressure: ready low for five ISSUE cycles.
        desc_rdy_i = 1'b0;
        cmd_req_i = 1'b1; cmd_addr_i = 3'd2;
        tick();
        cmd_req_i = 1'b0;
        tick();
        held = desc_data_o;
        chk("bp_data", 64'(held), 64'(exp_desc));
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld_held", 64'(desc_vld_o), 64'd1);
            chk("bp_data_stable", 64'(desc_data_o), 64'(exp_desc));
            tick();
        end
        chk("bp_vld_still", 64'(desc_vld_o), 64'd1);
        desc_rdy_i = 1'b1;
        tick();
        chk("bp_vld_drop", 64'(desc_vld_o), 64'd0);
        dma_done_i = 1'b1;
        ok_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            dma_done_i = 1'b0;
            if (cmd_ok_o) ok_cnt++;
        end
        chk("bp_ok_once", 64'(ok_cnt), 64'd1);

        // Sleep requested while idle is ignored.
        core_sleep_en_i = 1'b1;
        tick();
        core_sleep_en_i = 1'b0;
        cmd_req_i = 1'b1; cmd_addr_i = 3'd3;
        tick(); cmd_req_i = 1'b0;
        tick();
        chk("idle_sleep_cmd", 64'(desc_cmd_o), 64'd3);
        tick();
        dma_done_i = 1'b1;
        tick(); dma_done_i = 1'b0;
        chk("idle_sleep_ok", 64'(cmd_ok_o), 64'd1);
        chk("idle_sleep_irq", 64'(core_wakeup_irq_o), 64'd0);
        tick();

        // Sleep pulsed in WAIT produces a wake-up with ok.
        cmd_req_i = 1'b1; cmd_addr_i = 3'd2;
        tick(); cmd_req_i = 1'b0;
        tick();
        tick();                                      // WAIT
        core_sleep_en_i = 1'b1;
        tick();
        core_sleep_en_i = 1'b0;
        chk("slp_ok_early", 64'(cmd_ok_o), 64'd0);
        chk("slp_irq_early", 64'(core_wakeup_irq_o), 64'd0);
        dma_done_i = 1'b1;
        tick(); dma_done_i = 1'b0;
        chk("slp_ok", 64'(cmd_ok_o), 64'd1);
        chk("slp_irq", 64'(core_wakeup_irq_o), 64'd1);
        tick();
        chk("slp_ok_drop", 64'(cmd_ok_o), 64'd0);
        chk("slp_irq_drop", 64'(core_wakeup_irq_o), 64'd0);

        // Done coincident with the last counter value: no error.
        cmd_req_i = 1'b1; cmd_addr_i = 3'd1;
        tick(); cmd_req_i = 1'b0;
        tick();                                      // ISSUE, rdy=1
        tick();                                      // WAIT, count 0
        for (int i = 0; i < 1023; i++) tick();       // WAIT, count 1023
        chk("edge_ok_early", 64'(cmd_ok_o), 64'd0);
        dma_done_i = 1'b1;
        tick(); dma_done_i = 1'b0;
        chk("edge_ok", 64'(cmd_ok_o), 64'd1);
        chk("edge_err", 64'(err_o), 64'd0);
        tick();

        // Timeout: ok arrives 1024 edges after the handshake edge.
        cmd_req_i = 1'b1; cmd_addr_i = 3'd1;
        tick(); cmd_req_i = 1'b0;
        tick();                                      // ISSUE
        chk("to_err_before", 64'(err_o), 64'd0);
        n = 0;
        while (n < 2000) begin
            tick();
            n++;
            if (cmd_ok_o) break;
        end
        chk("to_latency", 64'(n), 64'd1025);
        chk("to_err", 64'(err_o), 64'd1);
        tick();
        cmd_req_i = 1'b1; cmd_addr_i = 3'd1;
        tick(); cmd_req_i = 1'b0;
        chk("to_err_next_gnt", 64'(err_o), 64'd1);
        tick(); tick();
        dma_done_i = 1'b1;
        tick(); dma_done_i = 1'b0;
        chk("to_next_ok", 64'(cmd_ok_o), 64'd1);
        chk("to_err_next_ok", 64'(err_o), 64'd1);
        tick();

        // Snapshot race on rf[0].
        cfg_wr(7'd0, 13'h0AB);
        cfg_wr(7'd1, 13'h155);
        cmd_req_i = 1'b1; cmd_addr_i = 3'd0;
        tick();                                      // GNT
        cmd_req_i = 1'b0;
        cfg_vld_i = 1'b1; cfg_addr_i = 7'd0; cfg_data_i = 13'h1FFF;
        tick();                                      // ISSUE
        cfg_vld_i = 1'b0;
        exp_desc = {13'h000, 13'h000, 13'h155, 13'h0AB};
        chk("race_old", 64'(desc_data_o), 64'(exp_desc));
        chk("race_cmd", 64'(desc_cmd_o), 64'd0);
        tick();
        dma_done_i = 1'b1;
        tick(); dma_done_i = 1'b0;
        tick();
        cmd_req_i = 1'b1; cmd_addr_i = 3'd0;
        tick(); cmd_req_i = 1'b0;
        tick();
        exp_desc = {13'h000, 13'h000, 13'h155, 13'h1FFF};
        chk("race_new", 64'(desc_data_o), 64'(exp_desc));
        tick();
        dma_done_i = 1'b1;
        tick(); dma_done_i = 1'b0;
        tick();

        // Reset while the descriptor is valid.
        desc_rdy_i = 1'b0;
        cmd_req_i = 1'b1; cmd_addr_i = 3'd2;
        tick(); cmd_req_i = 1'b0;
        core_sleep_en_i = 1'b1;
        tick();
        chk("rst_pre_vld", 64'(desc_vld_o), 64'd1);
        rst = 1'b1;
        tick();
        chk_all_zero("rst_mid");
        rst = 1'b0;
        core_sleep_en_i = 1'b0;
        desc_rdy_i = 1'b1;
        dma_done_i = 1'b1;
        ok_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cmd_ok_o || core_wakeup_irq_o || desc_vld_o) ok_cnt++;
        end
        dma_done_i = 1'b0;
        chk("rst_no_pulse", 64'(ok_cnt), 64'd0);
        cmd_req_i = 1'b1; cmd_addr_i = 3'd2;
        tick(); cmd_req_i = 1'b0;
        tick();
        chk("rst_rf_cleared", 64'(desc_data_o), 64'd0);
        chk("rst_new_vld", 64'(desc_vld_o), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
